// File: rtl/uart_send_fifo.sv
// UART transmitter with elaboration-time frame format and baud rate, fed by a
// small input FIFO so queued bytes go out back-to-back.
module uart_send_fifo #(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD       = 115200,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 SendEn,
    input  logic [DATA_BITS-1:0] SendData,
    output logic                 SendFull,
    output logic                 SendErr,
    output logic                 SendBusy,
    output logic                 SendDone,
    output logic                 UartTx
);

    localparam int BAUD_DIV = (CLK_FREQ + BAUD / 2) / BAUD;
    localparam int CNT_W    = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam int PTR_W    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(BAUD_DIV - 1);
    localparam logic [3:0]       DATA_LAST = 4'(DATA_BITS - 1);
    localparam logic [3:0]       STOP_LAST = 4'(STOP_BITS - 1);
    localparam logic [PTR_W:0]   DEPTH_CNT = (PTR_W + 1)'(FIFO_DEPTH);

    generate
        if (DATA_BITS < 5 || DATA_BITS > 9 || PARITY < 0 || PARITY > 2 ||
            STOP_BITS < 1 || STOP_BITS > 2 || FIFO_DEPTH < 2 ||
            (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || BAUD_DIV < 2) begin : gCfgCheck
            $error("uart_send_fifo: illegal parameter combination");
        end
    endgenerate

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    // Even parity is the XOR of the data bits; odd parity is its inverse.
    function automatic logic calcParity(input logic [DATA_BITS-1:0] word);
        logic p;
        p = ^word;
        return (PARITY == 1) ? ~p : p;
    endfunction

    logic [DATA_BITS-1:0] fifoMem_r [FIFO_DEPTH];
    logic [PTR_W-1:0]     wrPtr_r;
    logic [PTR_W-1:0]     rdPtr_r;
    logic [PTR_W:0]       count_r;
    logic [PTR_W:0]       countNext_s;
    logic                 full_r;
    logic                 push_s;
    logic                 pop_s;

    state_t               state_r;
    state_t               stateNext_s;
    logic [CNT_W-1:0]     baudCnt_r;
    logic [3:0]           bitIdx_r;
    logic [DATA_BITS-1:0] shift_r;
    logic                 parityBit_r;
    logic                 bitEnd_s;
    logic                 frameEnd_s;
    logic                 txBit_s;

    logic                 tx_r;
    logic                 done_r;
    logic                 err_r;
    logic                 busy_r;

    // Full is a registered flag, so a write seen while full is dropped even if a pop happens on the same edge.
    assign push_s   = SendEn & ~full_r;
    assign bitEnd_s = (baudCnt_r == BAUD_LAST);

    // Next FIFO occupancy from the push/pop pair.
    always_comb begin
        countNext_s = count_r;
        case ({push_s, pop_s})
            2'b10:   countNext_s = count_r + (PTR_W + 1)'(1);
            2'b01:   countNext_s = count_r - (PTR_W + 1)'(1);
            default: countNext_s = count_r;
        endcase
    end

    // FIFO storage, pointers, occupancy and full flag.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wrPtr_r <= '0;
            rdPtr_r <= '0;
            count_r <= '0;
            full_r  <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifoMem_r[i] <= '0;
            end
        end else begin
            if (push_s) begin
                fifoMem_r[wrPtr_r] <= SendData;
                wrPtr_r            <= wrPtr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rdPtr_r <= rdPtr_r + PTR_W'(1);
            end
            count_r <= countNext_s;
            full_r  <= (countNext_s == DEPTH_CNT);
        end
    end

    // Frame sequencing; a pending word is popped straight from STOP into START.
    always_comb begin
        stateNext_s = state_r;
        pop_s       = 1'b0;
        frameEnd_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (count_r != '0) begin
                    pop_s       = 1'b1;
                    stateNext_s = ST_START;
                end else begin
                    stateNext_s = ST_IDLE;
                end
            end
            ST_START: begin
                if (bitEnd_s) begin
                    stateNext_s = ST_DATA;
                end else begin
                    stateNext_s = ST_START;
                end
            end
            ST_DATA: begin
                if (bitEnd_s && bitIdx_r == DATA_LAST) begin
                    stateNext_s = (PARITY != 0) ? ST_PARITY : ST_STOP;
                end else begin
                    stateNext_s = ST_DATA;
                end
            end
            ST_PARITY: begin
                if (bitEnd_s) begin
                    stateNext_s = ST_STOP;
                end else begin
                    stateNext_s = ST_PARITY;
                end
            end
            ST_STOP: begin
                if (bitEnd_s && bitIdx_r == STOP_LAST) begin
                    frameEnd_s = 1'b1;
                    if (count_r != '0) begin
                        pop_s       = 1'b1;
                        stateNext_s = ST_START;
                    end else begin
                        stateNext_s = ST_IDLE;
                    end
                end else begin
                    stateNext_s = ST_STOP;
                end
            end
            default: begin
                stateNext_s = ST_IDLE;
            end
        endcase
    end

    // Line level for the current state.
    always_comb begin
        txBit_s = 1'b1;
        case (state_r)
            ST_IDLE:   txBit_s = 1'b1;
            ST_START:  txBit_s = 1'b0;
            ST_DATA:   txBit_s = shift_r[0];
            ST_PARITY: txBit_s = parityBit_r;
            ST_STOP:   txBit_s = 1'b1;
            default:   txBit_s = 1'b1;
        endcase
    end

    // State register, baud counter, bit index and shift register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r     <= ST_IDLE;
            baudCnt_r   <= '0;
            bitIdx_r    <= 4'd0;
            shift_r     <= '0;
            parityBit_r <= 1'b0;
        end else begin
            state_r <= stateNext_s;
            if (state_r == ST_IDLE || bitEnd_s) begin
                baudCnt_r <= '0;
            end else begin
                baudCnt_r <= baudCnt_r + CNT_W'(1);
            end
            if (stateNext_s != state_r) begin
                bitIdx_r <= 4'd0;
            end else if (bitEnd_s) begin
                bitIdx_r <= bitIdx_r + 4'd1;
            end
            if (pop_s) begin
                shift_r     <= fifoMem_r[rdPtr_r];
                parityBit_r <= calcParity(fifoMem_r[rdPtr_r]);
            end else if (state_r == ST_DATA && bitEnd_s) begin
                shift_r <= shift_r >> 1;
            end
        end
    end

    // Registered outputs; the line lags the state by one cycle, and done/busy are aligned with it.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            tx_r   <= 1'b1;
            done_r <= 1'b0;
            err_r  <= 1'b0;
            busy_r <= 1'b0;
        end else begin
            tx_r   <= txBit_s;
            done_r <= frameEnd_s;
            err_r  <= SendEn & full_r;
            busy_r <= push_s | (count_r != '0) | (state_r != ST_IDLE);
        end
    end

    assign UartTx   = tx_r;
    assign SendDone = done_r;
    assign SendErr  = err_r;
    assign SendBusy = busy_r;
    assign SendFull = full_r;

endmodule

// File: tb/tb_uart_send_fifo.sv
// Scoreboard bench for uart_send_fifo: three instances cover the default 8N1
// format, 7E2 and 8O1; frames are captured bit by bit and compared to a model.
module tb_uart_send_fifo;

    localparam int BAUD_DIV = 434;
    localparam int LEN_A    = 10 * BAUD_DIV;
    localparam int LEN_B    = 11 * BAUD_DIV;
    localparam int LEN_C    = 11 * BAUD_DIV;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    logic       enA = 1'b0, fullA, errA, busyA, doneA, txA;
    logic [7:0] dataA = 8'h00;
    logic       enB = 1'b0, fullB, errB, busyB, doneB, txB;
    logic [6:0] dataB = 7'h00;
    logic       enC = 1'b0, fullC, errC, busyC, doneC, txC;
    logic [7:0] dataC = 8'h00;

    uart_send_fifo dutA (
        .clk(clk), .rstn(rstn), .SendEn(enA), .SendData(dataA), .SendFull(fullA),
        .SendErr(errA), .SendBusy(busyA), .SendDone(doneA), .UartTx(txA)
    );
    uart_send_fifo #(.DATA_BITS(7), .PARITY(2), .STOP_BITS(2)) dutB (
        .clk(clk), .rstn(rstn), .SendEn(enB), .SendData(dataB), .SendFull(fullB),
        .SendErr(errB), .SendBusy(busyB), .SendDone(doneB), .UartTx(txB)
    );
    uart_send_fifo #(.PARITY(1)) dutC (
        .clk(clk), .rstn(rstn), .SendEn(enC), .SendData(dataC), .SendFull(fullC),
        .SendErr(errC), .SendBusy(busyC), .SendDone(doneC), .UartTx(txC)
    );

    int   sel = 0;
    logic selTx, selDone, selBusy, selErr;
    always_comb begin
        case (sel)
            1:       begin selTx = txB; selDone = doneB; selBusy = busyB; selErr = errB; end
            2:       begin selTx = txC; selDone = doneC; selBusy = busyC; selErr = errC; end
            default: begin selTx = txA; selDone = doneA; selBusy = busyA; selErr = errA; end
        endcase
    end

    logic [12:0] sb [$];
    int nVec = 0;
    int nFail = 0;

    // Reference frame, LSB = start bit; positions past the frame read as idle 1.
    function automatic logic [12:0] expBits(input logic [8:0] d, input int nData, input int par);
        logic [12:0] b;
        logic        p;
        b    = '1;
        b[0] = 1'b0;
        p    = 1'b0;
        for (int i = 0; i < nData; i++) begin
            b[1 + i] = d[i];
            p        = p ^ d[i];
        end
        if (par == 1) b[1 + nData] = ~p;
        else if (par == 2) b[1 + nData] = p;
        return b;
    endfunction

    // Waits (bounded) for a falling edge, then samples every cycle of one frame.
    task automatic captureFrame(input int len, input int waitMax, output logic got,
                                output int waited, output logic [12:0] bits, output logic glitch,
                                output int doneAt, output int doneCnt, output logic busyDrop,
                                output logic errSeen);
        got = 1'b0; waited = 0; bits = '1; glitch = 1'b0;
        doneAt = 0; doneCnt = 0; busyDrop = 1'b0; errSeen = 1'b0;
        while (!got && waited < waitMax) begin
            @(negedge clk);
            if (selTx === 1'b0) got = 1'b1;
            else waited++;
        end
        if (got) begin
            for (int c = 1; c <= len; c++) begin
                int bi, ph;
                if (c > 1) @(negedge clk);
                bi = (c - 1) / BAUD_DIV;
                ph = (c - 1) % BAUD_DIV;
                if (ph == 0) bits[bi] = selTx;
                else if (selTx !== bits[bi]) glitch = 1'b1;
                if (selDone === 1'b1) begin
                    doneCnt++;
                    if (doneAt == 0) doneAt = c;
                end
                if (selBusy !== 1'b1) busyDrop = 1'b1;
                if (selErr !== 1'b0) errSeen = 1'b1;
            end
        end
    endtask

    task automatic test_reset();
        logic [6:0] got;
        rstn = 1'b0;
        repeat (3) @(negedge clk);
        got = {txA, fullA, errA, busyA, doneA, txB, txC};
        nVec++;
        if (got !== 7'b1000011) begin
            nFail++; $display("FAIL reset_outputs: got %b want 1000011", got);
        end
        rstn = 1'b1;
        @(negedge clk);
        got = {txA, fullA, errA, busyA, doneA, txB, txC};
        nVec++;
        if (got !== 7'b1000011) begin
            nFail++; $display("FAIL idle_after_reset: got %b want 1000011", got);
        end
    endtask

    // Single write from idle, then full frame check; also used after the mid-frame reset.
    task automatic single_frame(input string tag, input int which, input logic [8:0] d,
                                input int nData, input int par, input int len);
        logic got, glitch, busyDrop, errSeen;
        int waited, doneAt, doneCnt;
        logic [12:0] bits, exp;
        sel = which;
        @(negedge clk);
        case (which)
            1:       begin enB = 1'b1; dataB = d[6:0]; end
            2:       begin enC = 1'b1; dataC = d[7:0]; end
            default: begin enA = 1'b1; dataA = d[7:0]; end
        endcase
        sb.push_back(expBits(d, nData, par));
        @(negedge clk);
        enA = 1'b0; enB = 1'b0; enC = 1'b0;
        nVec++;
        if (selBusy !== 1'b1 || selTx !== 1'b1) begin
            nFail++; $display("FAIL %s_busy_rise: busy %b tx %b want 1 1", tag, selBusy, selTx);
        end
        captureFrame(len, 20, got, waited, bits, glitch, doneAt, doneCnt, busyDrop, errSeen);
        nVec++;
        if (!got) begin
            nFail++; $display("FAIL %s_no_frame: no start bit within 20 cycles", tag);
        end else begin
            exp = sb.pop_front();
            // Sampling edge was one cycle back, so the line must fall one sampled cycle later.
            nVec++;
            if (waited !== 1) begin
                nFail++; $display("FAIL %s_latency: waited %0d want 1", tag, waited);
            end
            if (bits !== exp || glitch) begin
                nFail++; $display("FAIL %s_bits: got %b glitch %b want %b", tag, bits, glitch, exp);
            end
            nVec++;
            if (doneAt !== len || doneCnt !== 1 || busyDrop) begin
                nFail++; $display("FAIL %s_done: at %0d cnt %0d busyDrop %b want %0d 1 0",
                                  tag, doneAt, doneCnt, busyDrop, len);
            end
        end
        @(negedge clk);
        nVec++;
        if (selBusy !== 1'b0 || selTx !== 1'b1) begin
            nFail++; $display("FAIL %s_idle: busy %b tx %b want 0 1", tag, selBusy, selTx);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] vals [3];
        vals = '{8'h55, 8'hAA, 8'h0F};
        sel = 0;
        @(negedge clk);
        fork
            begin
                for (int i = 0; i < 3; i++) begin
                    enA = 1'b1; dataA = vals[i];
                    sb.push_back(expBits({1'b0, vals[i]}, 8, 0));
                    @(negedge clk);
                end
                enA = 1'b0;
            end
            begin
                for (int f = 0; f < 3; f++) begin
                    logic got, glitch, busyDrop, errSeen;
                    int waited, doneAt, doneCnt;
                    logic [12:0] bits, exp;
                    captureFrame(LEN_A, 20, got, waited, bits, glitch, doneAt, doneCnt, busyDrop, errSeen);
                    nVec++;
                    if (!got) begin
                        nFail++; $display("FAIL b2b_frame%0d: no start bit", f);
                    end else begin
                        exp = sb.pop_front();
                        if (bits !== exp || glitch) begin
                            nFail++; $display("FAIL b2b_bits%0d: got %b want %b", f, bits, exp);
                        end
                        nVec++;
                        if ((f > 0 && waited !== 0) || doneAt !== LEN_A || doneCnt !== 1 ||
                            busyDrop || errSeen) begin
                            nFail++; $display("FAIL b2b_timing%0d: gap %0d doneAt %0d cnt %0d busyDrop %b err %b want 0 %0d 1 0 0",
                                              f, waited, doneAt, doneCnt, busyDrop, errSeen, LEN_A);
                        end
                    end
                end
            end
        join
        @(negedge clk);
        nVec++;
        if (busyA !== 1'b0) begin
            nFail++; $display("FAIL b2b_busy_end: got %b want 0", busyA);
        end
    endtask

    task automatic test_overflow();
        int lowCnt;
        sel = 0;
        @(negedge clk);
        fork
            begin
                for (int i = 0; i < 6; i++) begin
                    enA = 1'b1; dataA = 8'(8'hC0 + i);
                    if (i < 5) sb.push_back(expBits({1'b0, 8'(8'hC0 + i)}, 8, 0));
                    @(negedge clk);
                    if (i == 3 || i == 4) begin
                        nVec++;
                        if (fullA !== (i == 4)) begin
                            nFail++; $display("FAIL ovf_full_w%0d: got %b want %b", i + 1, fullA, (i == 4));
                        end
                    end
                    if (i == 5) begin
                        nVec++;
                        if (errA !== 1'b1) begin
                            nFail++; $display("FAIL ovf_err_pulse: got %b want 1", errA);
                        end
                    end
                end
                enA = 1'b0;
                @(negedge clk);
                nVec++;
                if (errA !== 1'b0) begin
                    nFail++; $display("FAIL ovf_err_width: got %b want 0", errA);
                end
            end
            begin
                for (int f = 0; f < 5; f++) begin
                    logic got, glitch, busyDrop, errSeen;
                    int waited, doneAt, doneCnt;
                    logic [12:0] bits, exp;
                    captureFrame(LEN_A, 20, got, waited, bits, glitch, doneAt, doneCnt, busyDrop, errSeen);
                    nVec++;
                    if (!got) begin
                        nFail++; $display("FAIL ovf_frame%0d: no start bit", f);
                    end else begin
                        exp = sb.pop_front();
                        if (bits !== exp || glitch || (f > 0 && waited !== 0) || doneAt !== LEN_A) begin
                            nFail++; $display("FAIL ovf_bits%0d: got %b gap %0d doneAt %0d want %b 0 %0d",
                                              f, bits, waited, doneAt, exp, LEN_A);
                        end
                    end
                end
            end
        join
        lowCnt = 0;
        repeat (600) begin
            @(negedge clk);
            if (txA !== 1'b1) lowCnt++;
        end
        nVec++;
        if (lowCnt !== 0 || busyA !== 1'b0) begin
            nFail++; $display("FAIL ovf_no_sixth: low cycles %0d busy %b want 0 0", lowCnt, busyA);
        end
    endtask

    task automatic test_reset_midframe();
        int lowCnt;
        sel = 0;
        @(negedge clk);
        for (int i = 1; i <= 3; i++) begin
            enA = 1'b1; dataA = 8'(i);
            @(negedge clk);
        end
        enA = 1'b0;
        repeat (3 * BAUD_DIV) @(negedge clk);
        nVec++;
        if (busyA !== 1'b1 || fullA !== 1'b0) begin
            nFail++; $display("FAIL midrst_pre: busy %b full %b want 1 0", busyA, fullA);
        end
        #2 rstn = 1'b0;
        #1;
        nVec++;
        if (txA !== 1'b1 || busyA !== 1'b0 || fullA !== 1'b0 || doneA !== 1'b0) begin
            nFail++; $display("FAIL midrst_async: tx %b busy %b full %b done %b want 1 0 0 0",
                              txA, busyA, fullA, doneA);
        end
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b1;
        lowCnt = 0;
        repeat (4500) begin
            @(negedge clk);
            if (txA !== 1'b1 || busyA !== 1'b0) lowCnt++;
        end
        nVec++;
        if (lowCnt !== 0) begin
            nFail++; $display("FAIL midrst_residual: active cycles %0d want 0", lowCnt);
        end
        single_frame("midrst_a5", 0, 9'h0A5, 8, 0, LEN_A);
    endtask

    initial begin
        test_reset();
        single_frame("single_12", 0, 9'h012, 8, 0, LEN_A);
        test_back_to_back();
        test_overflow();
        single_frame("even_7e2", 1, 9'h041, 7, 2, LEN_B);
        single_frame("odd_8o1", 2, 9'h012, 8, 1, LEN_C);
        test_reset_midframe();
        $display("== %0d vectors applied, %0d miscompares ==", nVec, nFail);
        $finish;
    end

endmodule
